// File: rtl/mem_responder_if.sv
// Control handshake between the sequencer and the memory responder.
// The shared data bus stays a plain inout on the responder itself.
interface mem_responder_if;
    logic load_MAR;
    logic load_MDR;
    logic MDR_bus;
    logic CS;
    logic R_NW;
    logic busy;
    logic mem_ready;

    modport master (
        output load_MAR, load_MDR, MDR_bus, CS, R_NW,
        input  busy, mem_ready
    );

    modport slave (
        input  load_MAR, load_MDR, MDR_bus, CS, R_NW,
        output busy, mem_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Bus-side memory: MAR/MDR latches, word RAM with fixed access latency,
// one-cycle mem_ready pulse on completion, tri-state MDR drive onto sysbus.
module mem_responder #(
    parameter int WORD_W  = 8,
    parameter int OP_W    = 3,
    parameter int LATENCY = 2
) (
    input  logic                clock,
    input  logic                n_reset,
    mem_responder_if.slave      ctl,
    inout  wire  [WORD_W-1:0]   sysbus
);
    localparam int ADDR_W = WORD_W - OP_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [WORD_W-1:0]   mdr_q, mdr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_read_q, op_read_d;
    logic                ram_we;
    logic [WORD_W-1:0]   ram_q [DEPTH];

    assign sysbus        = ctl.MDR_bus ? mdr_q : {WORD_W{1'bz}};
    assign ctl.busy      = (state_q == WAIT);
    assign ctl.mem_ready = (state_q == DONE);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            mdr_q     <= '0;
            cnt_q     <= '0;
            op_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            cnt_q     <= cnt_d;
            op_read_q <= op_read_d;
        end
    end

    // RAM is never reset; ram_we is only raised from WAIT, so reset aborts writes.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_q[mar_q] <= mdr_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        cnt_d     = cnt_q;
        op_read_d = op_read_q;
        ram_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctl.load_MAR) begin
                    mar_d = sysbus[ADDR_W-1:0];
                end
                if (ctl.load_MDR) begin
                    mdr_d = sysbus;
                end
                if (ctl.CS) begin
                    state_d   = WAIT;
                    op_read_d = ctl.R_NW;
                    cnt_d     = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (op_read_q) begin
                        mdr_d = ram_q[mar_q];
                    end else begin
                        ram_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
